wb_ws2812b_rx: RTL and testbench
================================

# wb_ws2812b_rx

- Receives a WS2812B serial data stream on `din` and decodes the first 24 bits of each frame into green/red/blue bytes.
- Bits after the first 24 are forwarded to `dout`, so several receivers can be chained like real LEDs.
- Decoded colours, error flags and a frame counter are exposed through the team's 8-bit Wishbone slave register map.
- Used for loopback testing of the LED transmitter, and for FPGA-to-FPGA LED-protocol links.

## Interface

Parameters:
- CLOCK_FREQ, 27000000, clk frequency in Hz; all pulse thresholds are derived from it.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wb_adr_i  in  8  register address; only bits [2:0] are decoded
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  registered read data
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  single-cycle acknowledge
- din  in  1  asynchronous WS2812B data input
- dout  out  1  forwarded data for the next device in the chain

## Operation

**Thresholds** (integer division; values at 27 MHz in brackets):
- T_MIN = CLOCK_FREQ·2/10^7 [5]
- T_THR = CLOCK_FREQ·6/10^7 [16]
- T_MAX = CLOCK_FREQ·15/10^7 [40]
- T_RST = CLOCK_FREQ/20000 [1350]

**Input stage**
- `din` passes through a 2-flop synchronizer, giving `din_s`.
- Rising and falling edges are detected on `din_s`.
- A single 16-bit counter measures each high or low phase and saturates at T_RST.

**State machine**
- WAIT_RST: entered on reset and after an abort. Counts low time; any high restarts the count. On reaching T_RST, go to IDLE.
- IDLE: frame boundary; bit count is 0. A rising edge goes to HIGH.
- HIGH: counts high width.
  - Counter exceeding T_MAX sets err_long and goes to WAIT_RST.
  - On a falling edge with width < T_MIN: set err_short and discard the pulse.
  - On a falling edge with width ≥ T_THR: the bit is 1.
  - On any other falling edge: the bit is 0.
  - After deciding a bit, go to LOW.
- LOW: counts low width.
  - A rising edge goes to HIGH.
  - Low time reaching T_RST ends the frame and goes to IDLE.
  - If the frame ends with 1–23 bits captured, set err_partial; the colour registers are not changed.

**Bit accounting**
- Bits 0–23 shift MSB-first into a 24-bit shift register.
- On the 24th bit, {G,R,B} are latched from the shift register, `new` is set, and the frame counter increments (8-bit, wraps 255→0).
- Bits 24 and later are not decoded; the `fwd` flag is set from the 24th falling edge until the end of the frame.

**Registers** (wb_adr_i[2:0]):
- 0: green (RO)
- 1: red (RO)
- 2: blue (RO)
- 3: status, bits as follows:
  - bit0 new
  - bit1 err_short
  - bit2 err_long
  - bit3 err_partial
  - bit4 busy (state is HIGH or LOW)
  - bits [7:5] read 0
  - Bits 0–3 are write-1-to-clear.
- 4: frame counter (RO)
- 5–7: read 0
- Writes to any address other than 3 are ignored.

**Boundary conditions**
- A flag set by hardware and cleared by W1C in the same cycle ends up set (set wins).
- Reset mid-frame drops the partial frame with no flag, and the receiver returns to WAIT_RST.

## Timing

**Reset values**
- wb_dat_o = 0, wb_ack_o = 0, dout = 0.
- All registers and flags = 0; state = WAIT_RST.

**Wishbone**
- wb_ack_o asserts one cycle after a cycle with cyc&stb while ack is low, and lasts exactly one cycle.
- Back-to-back strobes are acknowledged every other cycle.
- Read data is valid together with the ack.
- wb_dat_o holds its value between reads.

**Latencies**
- Edge on `din` to edge on `din_s`: 2 clk.
- Colour registers and `new` update 1 clk after the 24th falling edge is seen on `din_s`, i.e. 3 clk after `din`.
- A read in that same cycle returns the old value.

**Pulse measurement**
- The measured high width equals the `din` high width in clk cycles (synchronizer delay cancels).
- Thresholds are inclusive as stated in Operation.

## Configuration

- WS2812B_RX_PASSTHRU_EN defined:
  - While `fwd` is set, `dout` <= `din_s` on every clk, so `dout` follows `din` with a 3 clk delay and pulse widths are preserved exactly.
  - At all other times `dout` is 0.
- Undefined:
  - `dout` is tied to 0.
  - The `fwd` logic is still present for bit accounting.

## Structure

- Package `ws2812b_pkg` holds:
  - register address constants
  - status bit positions
  - state encoding
  - threshold functions of CLOCK_FREQ (shared with the transmitter)
- Sub-module `ws2812b_bit_decoder` holds the synchronizer, width counter and state machine. Its outputs are:
  - bit_valid, bit_val
  - frame_end
  - err_short, err_long
  - din_s
- The top level holds the bit counter, shift register, latches, pass-through and Wishbone logic.

## Test plan

All scenarios at 27 MHz. Bit encoding: bit0 = 11 high / 23 low; bit1 = 22 high / 12 low.

- Frame decode: 1400 clk low, then 24 bits of 0x123456, then 1400 low → reg0=0x12, reg1=0x34, reg2=0x56, status=0x01, reg4=0x01.
- W1C: write 0x01 to reg3 → reg3 reads 0x00. With a latch in the same cycle as the write → bit0 stays 1.
- Chained frame: 48 bits 0xAABBCC112233 → regs read AA/BB/CC.
  - With WS2812B_RX_PASSTHRU_EN: `dout` carries exactly 24 pulses encoding 0x112233 with identical widths.
  - Without it: `dout` stays 0.
- Partial frame: 10 bits, then 1400 low → status=0x08; regs unchanged; reg4 unchanged.
- Width errors:
  - 3-clk high pulse → status bit1 set.
  - 60-clk high pulse → bit2 set; following bits ignored until 1350 clk low.
- Mid-frame reset: rst asserted at bit 12 → all registers 0, `dout` 0, ack 0. A frame starting without a preceding 1350-clk low is ignored.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: register map, status bit positions, receiver
// state encoding and pulse thresholds derived from the clock frequency.
package ws2812b_pkg;

   localparam logic [2:0] ADR_GREEN  = 3'd0;
   localparam logic [2:0] ADR_RED    = 3'd1;
   localparam logic [2:0] ADR_BLUE   = 3'd2;
   localparam logic [2:0] ADR_STATUS = 3'd3;
   localparam logic [2:0] ADR_FRAMES = 3'd4;

   localparam int STAT_NEW         = 0;
   localparam int STAT_ERR_SHORT   = 1;
   localparam int STAT_ERR_LONG    = 2;
   localparam int STAT_ERR_PARTIAL = 3;
   localparam int STAT_BUSY        = 4;

   typedef enum logic [1:0] {
      S_WAIT_RST,
      S_IDLE,
      S_HIGH,
      S_LOW
   } rx_state_t;

   function automatic logic [15:0] t_min(input longint cf);
      return 16'(cf * 2 / 10000000);
   endfunction

   function automatic logic [15:0] t_thr(input longint cf);
      return 16'(cf * 6 / 10000000);
   endfunction

   function automatic logic [15:0] t_max(input longint cf);
      return 16'(cf * 15 / 10000000);
   endfunction

   function automatic logic [15:0] t_rst(input longint cf);
      return 16'(cf / 20000);
   endfunction

endpackage

// File: rtl/ws2812b_bit_decoder.sv
// WS2812B line decoder: synchronizer, phase-width counter and the bit/frame
// state machine. Emits one-cycle bit, frame-end and width-error strobes.
module ws2812b_bit_decoder
   import ws2812b_pkg::*;
#(
   parameter int CLOCK_FREQ = 27000000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic bit_valid,
   output logic bit_val,
   output logic frame_end,
   output logic err_short,
   output logic err_long,
   output logic busy,
   output logic din_s
);

   localparam logic [15:0] T_MIN = t_min(CLOCK_FREQ);
   localparam logic [15:0] T_THR = t_thr(CLOCK_FREQ);
   localparam logic [15:0] T_MAX = t_max(CLOCK_FREQ);
   localparam logic [15:0] T_RST = t_rst(CLOCK_FREQ);

   logic [1:0]  r_sync;
   logic        r_din_d;
   logic [15:0] r_cnt;
   rx_state_t   r_state;
   rx_state_t   w_next;
   logic        w_rise;
   logic        w_fall;

   assign din_s  = r_sync[1];
   assign w_rise = r_sync[1] & ~r_din_d;
   assign w_fall = ~r_sync[1] & r_din_d;
   assign busy   = (r_state == S_HIGH) || (r_state == S_LOW);

   // r_cnt holds the number of cycles the current level has lasted before
   // this cycle, so on a falling edge it equals the completed high width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync  <= '0;
         r_din_d <= 1'b0;
         r_cnt   <= '0;
         r_state <= S_WAIT_RST;
      end else begin
         r_sync  <= {r_sync[0], din};
         r_din_d <= r_sync[1];
         if (w_rise || w_fall)
            r_cnt <= 16'd1;
         else if (r_cnt < T_RST)
            r_cnt <= r_cnt + 16'd1;
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      bit_valid = 1'b0;
      bit_val   = 1'b0;
      frame_end = 1'b0;
      err_short = 1'b0;
      err_long  = 1'b0;
      case (r_state)
         S_WAIT_RST: if (!r_sync[1] && r_cnt == T_RST) w_next = S_IDLE;
         S_IDLE:     if (w_rise) w_next = S_HIGH;
         S_HIGH: begin
            if (r_cnt > T_MAX) begin
               err_long = 1'b1;
               w_next   = S_WAIT_RST;
            end else if (w_fall) begin
               w_next = S_LOW;
               if (r_cnt < T_MIN) begin
                  err_short = 1'b1;
               end else begin
                  bit_valid = 1'b1;
                  bit_val   = (r_cnt >= T_THR);
               end
            end
         end
         S_LOW: begin
            if (w_rise) begin
               w_next = S_HIGH;
            end else if (r_cnt == T_RST) begin
               frame_end = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: w_next = S_WAIT_RST;
      endcase
   end

endmodule

// File: rtl/wb_ws2812b_rx.sv
// WS2812B receiver with 8-bit Wishbone register map. Define
// WS2812B_RX_PASSTHRU_EN to forward bits beyond the first 24 on dout.
module wb_ws2812b_rx
   import ws2812b_pkg::*;
#(
   parameter int CLOCK_FREQ = 27000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] wb_adr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   input  logic       wb_we_i,
   input  logic       wb_cyc_i,
   input  logic       wb_stb_i,
   output logic       wb_ack_o,
   input  logic       din,
   output logic       dout
);

   logic w_bit_valid, w_bit_val, w_frame_end, w_err_short, w_err_long;
   logic w_busy, w_din_s;

   ws2812b_bit_decoder #(.CLOCK_FREQ(CLOCK_FREQ)) u_dec (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .bit_valid (w_bit_valid),
      .bit_val   (w_bit_val),
      .frame_end (w_frame_end),
      .err_short (w_err_short),
      .err_long  (w_err_long),
      .busy      (w_busy),
      .din_s     (w_din_s)
   );

   logic [22:0] r_shift;
   logic [4:0]  r_bit_cnt;
   logic        r_fwd;
   logic [7:0]  r_green, r_red, r_blue, r_frames;
   logic        r_new, r_err_short, r_err_long, r_err_partial;
   logic        r_ack;
   logic [7:0]  r_dat;
   logic        w_access, w_last_bit, w_partial;
   logic [3:0]  w_w1c;
   logic [7:0]  w_rd_data;

   assign w_access   = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_w1c      = (w_access && wb_we_i && wb_adr_i[2:0] == ADR_STATUS) ? wb_dat_i[3:0] : 4'b0;
   assign w_last_bit = w_bit_valid && (r_bit_cnt == 5'd23);
   assign w_partial  = w_frame_end && (r_bit_cnt != 5'd0) && (r_bit_cnt < 5'd24);

   // Bit counter saturates at 24; later bits are only forwarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_fwd     <= 1'b0;
         r_green   <= '0;
         r_red     <= '0;
         r_blue    <= '0;
         r_frames  <= '0;
      end else if (w_err_long || w_frame_end) begin
         r_bit_cnt <= '0;
         r_fwd     <= 1'b0;
      end else if (w_bit_valid && r_bit_cnt < 5'd24) begin
         r_shift   <= {r_shift[21:0], w_bit_val};
         r_bit_cnt <= r_bit_cnt + 5'd1;
         if (w_last_bit) begin
            {r_green, r_red, r_blue} <= {r_shift, w_bit_val};
            r_frames <= r_frames + 8'd1;
            r_fwd    <= 1'b1;
         end
      end
   end

   // Hardware set takes priority over a simultaneous write-1-to-clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_new         <= 1'b0;
         r_err_short   <= 1'b0;
         r_err_long    <= 1'b0;
         r_err_partial <= 1'b0;
      end else begin
         r_new         <= (r_new & ~w_w1c[STAT_NEW]) | w_last_bit;
         r_err_short   <= (r_err_short & ~w_w1c[STAT_ERR_SHORT]) | w_err_short;
         r_err_long    <= (r_err_long & ~w_w1c[STAT_ERR_LONG]) | w_err_long;
         r_err_partial <= (r_err_partial & ~w_w1c[STAT_ERR_PARTIAL]) | w_partial;
      end
   end

   always_comb begin
      w_rd_data = 8'h00;
      case (wb_adr_i[2:0])
         ADR_GREEN:  w_rd_data = r_green;
         ADR_RED:    w_rd_data = r_red;
         ADR_BLUE:   w_rd_data = r_blue;
         ADR_STATUS: w_rd_data = {3'b000, w_busy, r_err_partial, r_err_long, r_err_short, r_new};
         ADR_FRAMES: w_rd_data = r_frames;
         default:    w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_access;
         if (w_access && !wb_we_i)
            r_dat <= w_rd_data;
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat;

   logic w_unused_bus;
   assign w_unused_bus = ^{wb_adr_i[7:3], wb_dat_i[7:4]};

`ifdef WS2812B_RX_PASSTHRU_EN
   logic r_dout;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_dout <= 1'b0;
      else
         r_dout <= r_fwd & w_din_s;
   end
   assign dout = r_dout;
`else
   logic w_unused_fwd;
   assign w_unused_fwd = w_din_s & r_fwd;
   assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ws2812b_rx.sv
// Directed bench for wb_ws2812b_rx at 27 MHz; WS2812B_RX_PASSTHRU_EN selects
// the expected dout behaviour on chained frames.
module tb_wb_ws2812b_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wb_adr_i = 8'h00;
   logic [7:0] wb_dat_i = 8'h00;
   logic [7:0] wb_dat_o;
   logic       wb_we_i = 1'b0;
   logic       wb_cyc_i = 1'b0;
   logic       wb_stb_i = 1'b0;
   logic       wb_ack_o;
   logic       din = 1'b0;
   logic       dout;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   wb_ws2812b_rx #(.CLOCK_FREQ(27000000)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_ack_o (wb_ack_o),
      .din      (din),
      .dout     (dout)
   );

   // dout pulse monitor: counts pulses, decodes widths into bits
   logic        mon_clr = 1'b0;
   logic        mon_prev = 1'b0;
   int          mon_hi = 0;
   int          mon_pulses = 0;
   int          mon_bad = 0;
   logic [23:0] mon_val = 24'h0;

   always @(negedge clk) begin
      if (mon_clr) begin
         mon_prev   <= 1'b0;
         mon_hi     <= 0;
         mon_pulses <= 0;
         mon_bad    <= 0;
         mon_val    <= 24'h0;
      end else begin
         mon_prev <= dout;
         if (dout) begin
            mon_hi <= mon_hi + 1;
         end else if (mon_prev) begin
            mon_pulses <= mon_pulses + 1;
            mon_val    <= {mon_val[22:0], (mon_hi >= 16)};
            if (mon_hi != 11 && mon_hi != 22) mon_bad <= mon_bad + 1;
            mon_hi <= 0;
         end
      end
   end

   task automatic idle_low(input int n);
      din = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      din = 1'b1;
      repeat (hi) @(negedge clk);
      din = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) pulse(22, 12);
      else   pulse(11, 23);
   endtask

   task automatic send_bits(input logic [63:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
   endtask

   task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
      int n;
      n = 0;
      wb_adr_i = {5'b0, a};
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(negedge clk);
      while (!wb_ack_o && n < 4) begin
         @(negedge clk);
         n++;
      end
      d = wb_dat_o;
      n_checks++;
      if (wb_ack_o !== 1'b1) $display("FAIL rd_ack adr=%0d: ack=%b required 1", a, wb_ack_o);
      else n_pass++;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [7:0] v);
      int n;
      n = 0;
      wb_adr_i = {5'b0, a};
      wb_dat_i = v;
      wb_we_i  = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(negedge clk);
      while (!wb_ack_o && n < 4) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (wb_ack_o !== 1'b1) $display("FAIL wr_ack adr=%0d: ack=%b required 1", a, wb_ack_o);
      else n_pass++;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      rst = 1'b1;
      din = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (wb_dat_o !== 8'h00) $display("FAIL reset_dat: got %h required 00", wb_dat_o);
      else n_pass++;
      n_checks++;
      if (wb_ack_o !== 1'b0) $display("FAIL reset_ack: got %b required 0", wb_ack_o);
      else n_pass++;
      n_checks++;
      if (dout !== 1'b0) $display("FAIL reset_dout: got %b required 0", dout);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      for (int a = 0; a < 5; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== 8'h00) $display("FAIL reset_reg%0d: got %h required 00", a, rd);
         else n_pass++;
      end
   endtask

   task automatic test_frame_decode();
      logic [7:0] rd;
      logic [7:0] exp [8];
      exp = '{8'h12, 8'h34, 8'h56, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
      idle_low(1400);
      send_bits(64'h123456, 24);
      idle_low(1400);
      for (int a = 0; a < 8; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== exp[a]) $display("FAIL decode_reg%0d: got %h required %h", a, rd, exp[a]);
         else n_pass++;
      end
      wb_write(3'd0, 8'hFF);
      wb_read(3'd0, rd);
      n_checks++;
      if (rd !== 8'h12) $display("FAIL ro_green: got %h required 12", rd);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic exp_ack;
      wb_adr_i = 8'h00;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_ack = (i % 2 == 0);
         n_checks++;
         if (wb_ack_o !== exp_ack) $display("FAIL b2b_ack%0d: got %b required %b", i, wb_ack_o, exp_ack);
         else n_pass++;
         if (i == 0) begin
            n_checks++;
            if (wb_dat_o !== 8'h12) $display("FAIL b2b_dat: got %h required 12", wb_dat_o);
            else n_pass++;
         end
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_w1c();
      logic [7:0] rd;
      logic [7:0] exp [5];
      exp = '{8'h0F, 8'h0F, 8'h0F, 8'h01, 8'h02};
      wb_write(3'd3, 8'h01);
      wb_read(3'd3, rd);
      n_checks++;
      if (rd !== 8'h00) $display("FAIL w1c_clear: got %h required 00", rd);
      else n_pass++;
      // frame 0x0F0F0F; clear 'new' in the exact cycle the colours latch
      send_bits(64'h078787, 23);
      din = 1'b1;
      repeat (22) @(negedge clk);
      din = 1'b0;
      @(negedge clk);
      @(negedge clk);
      wb_adr_i = 8'h03;
      wb_dat_i = 8'h01;
      wb_we_i  = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wb_ack_o !== 1'b1) $display("FAIL collide_ack: got %b required 1", wb_ack_o);
      else n_pass++;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      idle_low(1400);
      for (int a = 0; a < 5; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== exp[a]) $display("FAIL collide_reg%0d: got %h required %h", a, rd, exp[a]);
         else n_pass++;
      end
   endtask

   task automatic test_chain();
      logic [7:0] rd;
      logic [7:0] exp [5];
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h03};
      wb_write(3'd3, 8'h0F);
      mon_clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mon_clr = 1'b0;
      send_bits(64'hAABBCC112233, 48);
      idle_low(1400);
      for (int a = 0; a < 5; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== exp[a]) $display("FAIL chain_reg%0d: got %h required %h", a, rd, exp[a]);
         else n_pass++;
      end
`ifdef WS2812B_RX_PASSTHRU_EN
      n_checks++;
      if (mon_pulses !== 24) $display("FAIL fwd_pulses: got %0d required 24", mon_pulses);
      else n_pass++;
      n_checks++;
      if (mon_val !== 24'h112233) $display("FAIL fwd_value: got %h required 112233", mon_val);
      else n_pass++;
      n_checks++;
      if (mon_bad !== 0) $display("FAIL fwd_widths: got %0d bad required 0", mon_bad);
      else n_pass++;
`else
      n_checks++;
      if (mon_pulses !== 0) $display("FAIL dout_quiet: got %0d pulses required 0", mon_pulses);
      else n_pass++;
`endif
      n_checks++;
      if (mon_hi !== 0) $display("FAIL dout_low_end: high for %0d cycles required 0", mon_hi);
      else n_pass++;
   endtask

   task automatic test_partial();
      logic [7:0] rd;
      logic [7:0] exp [5];
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'h08, 8'h03};
      wb_write(3'd3, 8'h0F);
      send_bits(64'h2A5, 10);
      idle_low(1400);
      for (int a = 0; a < 5; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== exp[a]) $display("FAIL partial_reg%0d: got %h required %h", a, rd, exp[a]);
         else n_pass++;
      end
   endtask

   task automatic test_width_errors();
      logic [7:0] rd;
      logic [7:0] exp [5];
      wb_write(3'd3, 8'h0F);
      pulse(3, 23);
      idle_low(1400);
      wb_read(3'd3, rd);
      n_checks++;
      if (rd !== 8'h02) $display("FAIL err_short: got %h required 02", rd);
      else n_pass++;
      wb_write(3'd3, 8'h0F);
      pulse(60, 20);
      send_bits(64'hFFFFFF, 24);
      idle_low(1400);
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'h04, 8'h03};
      for (int a = 0; a < 5; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== exp[a]) $display("FAIL err_long_reg%0d: got %h required %h", a, rd, exp[a]);
         else n_pass++;
      end
      wb_write(3'd3, 8'h0F);
      send_bits(64'hC3A501, 24);
      idle_low(1400);
      exp = '{8'hC3, 8'hA5, 8'h01, 8'h01, 8'h04};
      for (int a = 0; a < 5; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== exp[a]) $display("FAIL recover_reg%0d: got %h required %h", a, rd, exp[a]);
         else n_pass++;
      end
   endtask

   task automatic test_mid_frame_reset();
      logic [7:0] rd;
      send_bits(64'h123, 12);
      din = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wb_dat_o !== 8'h00) $display("FAIL midrst_dat: got %h required 00", wb_dat_o);
      else n_pass++;
      n_checks++;
      if (wb_ack_o !== 1'b0) $display("FAIL midrst_ack: got %b required 0", wb_ack_o);
      else n_pass++;
      n_checks++;
      if (dout !== 1'b0) $display("FAIL midrst_dout: got %b required 0", dout);
      else n_pass++;
      din = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send_bits(64'h123456, 24);
      idle_low(1400);
      for (int a = 0; a < 5; a++) begin
         wb_read(3'(a), rd);
         n_checks++;
         if (rd !== 8'h00) $display("FAIL midrst_reg%0d: got %h required 00", a, rd);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_frame_decode();
      test_back_to_back();
      test_w1c();
      test_chain();
      test_partial();
      test_width_errors();
      test_mid_frame_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
